requant_param_sched: RTL and testbench

- Per-channel requantisation scheduler in front of the requant/ReLU6 stage.
- Holds a per-channel parameter table (mul, bias, shift), written over a config port while idle.
- During a layer run it accepts a channel-major accumulator stream: for each pixel, channels 0..num_ch-1.
- Each accumulator is emitted on the output with its channel's mul/bias/shift plus the layer-wide relu6_max/relu6_en, ready to drive the requant stage directly. It also counts elements and pulses done at layer end.

---
 rtl/requant_param_sched.sv | 175 +++++++++++++++++
 tb/tb_requant_param_sched.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/requant_param_sched.sv
// rtl/requant_param_sched.sv - per-channel requant parameter scheduler
// Pairs each accumulator of a channel-major stream with its channel's mul/bias/shift.
module requant_param_sched #(
    parameter int ACC_W   = 32,
    parameter int MUL_W   = 16,
    parameter int BIAS_W  = 32,
    parameter int SHIFT_W = 6,
    parameter int DATA_W  = 8,
    parameter int NUM_CH  = 64,
    parameter int CH_W    = $clog2(NUM_CH),
    parameter int PIX_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [MUL_W-1:0]   cfg_mul,
    input  logic [BIAS_W-1:0]  cfg_bias,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               start,
    input  logic [CH_W:0]      num_ch,
    input  logic [PIX_W-1:0]   num_pix,
    input  logic [DATA_W-1:0]  relu6_max_in,
    input  logic               relu6_en_in,
    output logic               busy,
    output logic               done,
    output logic               err,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ACC_W-1:0]   in_acc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_acc,
    output logic [MUL_W-1:0]   out_mul,
    output logic [BIAS_W-1:0]  out_bias,
    output logic [SHIFT_W-1:0] out_shift,
    output logic [DATA_W-1:0]  out_relu6_max,
    output logic               out_relu6_en,
    output logic [CH_W-1:0]    out_ch,
    output logic               out_last
);

    localparam logic [CH_W:0] NUM_CH_V = (CH_W+1)'(NUM_CH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [MUL_W-1:0]   tbl_mul   [NUM_CH];
    logic [BIAS_W-1:0]  tbl_bias  [NUM_CH];
    logic [SHIFT_W-1:0] tbl_shift [NUM_CH];

    logic [CH_W:0]    num_ch_q;
    logic [PIX_W-1:0] num_pix_q;
    logic [CH_W-1:0]  ch_cnt;
    logic [PIX_W-1:0] pix_cnt;
    logic [CH_W:0]    num_ch_m1;
    logic [PIX_W-1:0] num_pix_m1;

    logic in_xfer, out_xfer, ch_wrap, is_last;
    logic start_ok, start_bad, cfg_idx_ok, cfg_wr, cfg_bad;

    assign num_ch_m1  = num_ch_q - (CH_W+1)'(1);
    assign num_pix_m1 = num_pix_q - PIX_W'(1);
    assign ch_wrap    = ({1'b0, ch_cnt} == num_ch_m1);
    assign is_last    = ch_wrap && (pix_cnt == num_pix_m1);

    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign busy     = (state != ST_IDLE);

    // Table writes only land while idle so a running layer sees a frozen table.
    assign cfg_idx_ok = ({1'b0, cfg_ch} < NUM_CH_V);
    assign cfg_wr     = cfg_we && (state == ST_IDLE) && cfg_idx_ok;
    assign cfg_bad    = cfg_we && !cfg_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (num_ch == '0 || num_ch > NUM_CH_V || num_pix == '0) begin
                        start_bad = 1'b1;
                    end else begin
                        start_ok  = 1'b1;
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (in_xfer && is_last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_xfer && out_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cfg_wr) begin
            tbl_mul[cfg_ch]   <= cfg_mul;
            tbl_bias[cfg_ch]  <= cfg_bias;
            tbl_shift[cfg_ch] <= cfg_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_ch_q      <= '0;
            num_pix_q     <= '0;
            ch_cnt        <= '0;
            pix_cnt       <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            out_valid     <= 1'b0;
            out_acc       <= '0;
            out_mul       <= '0;
            out_bias      <= '0;
            out_shift     <= '0;
            out_ch        <= '0;
            out_last      <= 1'b0;
            out_relu6_max <= '0;
            out_relu6_en  <= 1'b0;
        end else begin
            err  <= cfg_bad || start_bad;
            done <= (state == ST_DRAIN) && out_xfer && out_last;

            if (start_ok) begin
                num_ch_q      <= num_ch;
                num_pix_q     <= num_pix;
                out_relu6_max <= relu6_max_in;
                out_relu6_en  <= relu6_en_in;
                ch_cnt        <= '0;
                pix_cnt       <= '0;
            end else if (in_xfer) begin
                if (ch_wrap) begin
                    ch_cnt  <= '0;
                    pix_cnt <= pix_cnt + PIX_W'(1);
                end else begin
                    ch_cnt  <= ch_cnt + CH_W'(1);
                end
            end

            // A load in the same cycle as an output transfer keeps the pipe full.
            if (in_xfer) begin
                out_valid <= 1'b1;
                out_acc   <= in_acc;
                out_mul   <= tbl_mul[ch_cnt];
                out_bias  <= tbl_bias[ch_cnt];
                out_shift <= tbl_shift[ch_cnt];
                out_ch    <= ch_cnt;
                out_last  <= is_last;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_requant_param_sched.sv
// tb/tb_requant_param_sched.sv - scoreboard bench for requant_param_sched
// Expected outputs are built per layer from a model table in channel-major order.
module tb_requant_param_sched;

    localparam int ACC_W   = 32;
    localparam int MUL_W   = 16;
    localparam int BIAS_W  = 32;
    localparam int SHIFT_W = 6;
    localparam int DATA_W  = 8;
    localparam int NUM_CH  = 6;
    localparam int CH_W    = $clog2(NUM_CH);
    localparam int PIX_W   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [CH_W-1:0]    cfg_ch;
    logic [MUL_W-1:0]   cfg_mul;
    logic [BIAS_W-1:0]  cfg_bias;
    logic [SHIFT_W-1:0] cfg_shift;
    logic               start;
    logic [CH_W:0]      num_ch;
    logic [PIX_W-1:0]   num_pix;
    logic [DATA_W-1:0]  relu6_max_in;
    logic               relu6_en_in;
    logic               busy, done, err;
    logic               in_valid, in_ready;
    logic [ACC_W-1:0]   in_acc;
    logic               out_valid, out_ready;
    logic [ACC_W-1:0]   out_acc;
    logic [MUL_W-1:0]   out_mul;
    logic [BIAS_W-1:0]  out_bias;
    logic [SHIFT_W-1:0] out_shift;
    logic [DATA_W-1:0]  out_relu6_max;
    logic               out_relu6_en;
    logic [CH_W-1:0]    out_ch;
    logic               out_last;

    always #5 clk = ~clk;

    requant_param_sched #(
        .ACC_W(ACC_W), .MUL_W(MUL_W), .BIAS_W(BIAS_W), .SHIFT_W(SHIFT_W),
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W), .PIX_W(PIX_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mul(cfg_mul), .cfg_bias(cfg_bias), .cfg_shift(cfg_shift),
        .start(start), .num_ch(num_ch), .num_pix(num_pix),
        .relu6_max_in(relu6_max_in), .relu6_en_in(relu6_en_in),
        .busy(busy), .done(done), .err(err),
        .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_mul(out_mul), .out_bias(out_bias), .out_shift(out_shift),
        .out_relu6_max(out_relu6_max), .out_relu6_en(out_relu6_en),
        .out_ch(out_ch), .out_last(out_last)
    );

    typedef struct packed {
        logic [ACC_W-1:0]   acc;
        logic [MUL_W-1:0]   mul;
        logic [BIAS_W-1:0]  bias;
        logic [SHIFT_W-1:0] shift;
        logic [CH_W-1:0]    ch;
        logic               last;
        logic [DATA_W-1:0]  rmax;
        logic               ren;
    } out_t;

    typedef struct {
        int op;
        int a;
        int b;
        bit exp_err;
    } vec_t;

    int total = 0;
    int bad   = 0;

    out_t               exp_q[$];
    logic [MUL_W-1:0]   m_mul   [NUM_CH];
    logic [BIAS_W-1:0]  m_bias  [NUM_CH];
    logic [SHIFT_W-1:0] m_shift [NUM_CH];
    logic [DATA_W-1:0]  m_rmax;
    logic               m_ren;

    int   cyc = 0;
    int   done_cnt = 0;
    int   n_out = 0;
    int   last_xfer_cyc = -10;
    logic stall_prev = 1'b0;
    out_t prev_o;

    task automatic chk_b(input string name, input logic act, input logic expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic chk_o(input string name, input out_t act, input out_t expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic out_t dut_out();
        return {out_acc, out_mul, out_bias, out_shift, out_ch, out_last, out_relu6_max, out_relu6_en};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        out_t cur, e;
        cur = dut_out();
        if (!rst) begin
            if (stall_prev) chk_o("hold_stable", cur, prev_o);
            if (out_valid && !out_ready) chk_b("in_ready_stall", in_ready, 1'b0);
            if (out_valid && out_ready) begin
                n_out++;
                last_xfer_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk_i("extra_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk_o("out_fields", cur, e);
                end
            end
            if (done) begin
                done_cnt++;
                chk_i("done_timing", cyc, last_xfer_cyc + 1);
                chk_b("done_busy", busy, 1'b0);
                chk_i("done_pending", exp_q.size(), 0);
            end
            stall_prev = out_valid && !out_ready;
            prev_o = cur;
        end else begin
            stall_prev = 1'b0;
        end
    end

    function automatic out_t model_elem(input int c, input logic [ACC_W-1:0] acc, input logic last);
        out_t e;
        e.acc   = acc;
        e.mul   = m_mul[c];
        e.bias  = m_bias[c];
        e.shift = m_shift[c];
        e.ch    = CH_W'(c);
        e.last  = last;
        e.rmax  = m_rmax;
        e.ren   = m_ren;
        return e;
    endfunction

    task automatic cfg_write(input int ch);
        @(posedge clk); #1;
        cfg_we = 1'b1;
        cfg_ch = CH_W'(ch);
        cfg_mul = MUL_W'($urandom);
        cfg_bias = $urandom;
        cfg_shift = SHIFT_W'($urandom);
        m_mul[ch] = cfg_mul;
        m_bias[ch] = cfg_bias;
        m_shift[ch] = cfg_shift;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic start_layer(input int nc, input int np);
        start = 1'b1;
        num_ch = (CH_W+1)'(nc);
        num_pix = PIX_W'(np);
        relu6_max_in = DATA_W'($urandom_range(0, 255));
        relu6_en_in = 1'($urandom_range(0, 1));
        m_rmax = relu6_max_in;
        m_ren = relu6_en_in;
    endtask

    task automatic run_layer(input int nc, input int np, input int rdy_mode, input int vmode,
                             input int acc_base, input bit cfg_mid, input bit cfg_start);
        logic [ACC_W-1:0] accs[$];
        int k, lc, d0, n0, tot;
        tot = nc * np;
        for (int i = 0; i < tot; i++)
            accs.push_back(acc_base >= 0 ? ACC_W'(acc_base + i) : ACC_W'($urandom));
        @(posedge clk); #1;
        start_layer(nc, np);
        if (cfg_start) begin
            cfg_we = 1'b1;
            cfg_ch = '0;
            cfg_mul = MUL_W'($urandom);
            cfg_bias = $urandom;
            cfg_shift = SHIFT_W'($urandom);
            m_mul[0] = cfg_mul;
            m_bias[0] = cfg_bias;
            m_shift[0] = cfg_shift;
        end
        for (int p = 0; p < np; p++)
            for (int c = 0; c < nc; c++)
                exp_q.push_back(model_elem(c, accs[p*nc + c], (p == np-1) && (c == nc-1)));
        d0 = done_cnt;
        n0 = n_out;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_we = 1'b0;
        k = 0;
        lc = 0;
        while (done_cnt == d0 && lc < 4000) begin
            in_valid = (k < tot) && (vmode == 0 || $urandom_range(0, 3) != 0);
            in_acc = (k < tot) ? accs[k] : '0;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = (lc % 3 == 0);
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
            cfg_we = cfg_mid && (lc == 2);
            if (cfg_we) begin
                cfg_ch = CH_W'(1);
                cfg_mul = ~m_mul[1];
                cfg_bias = ~m_bias[1];
                cfg_shift = ~m_shift[1];
            end
            @(negedge clk);
            if (lc == 0) begin
                chk_b("run_busy", busy, 1'b1);
                chk_b("start_no_err", err, 1'b0);
            end
            if (cfg_mid && lc == 3) chk_b("busy_cfg_err", err, 1'b1);
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
            lc++;
        end
        in_valid = 1'b0;
        cfg_we = 1'b0;
        chk_i("run_done", done_cnt - d0, 1);
        chk_i("run_outputs", n_out - n0, tot);
        chk_i("run_accepted", k, tot);
        chk_b("run_idle", busy, 1'b0);
    endtask

    initial begin
        vec_t vecs[7];
        int   d0, k, lc;

        vecs[0] = '{1, 0, 1, 1'b1};
        vecs[1] = '{1, NUM_CH + 1, 1, 1'b1};
        vecs[2] = '{1, 3, 0, 1'b1};
        vecs[3] = '{0, NUM_CH, 0, 1'b1};
        vecs[4] = '{0, 7, 0, 1'b1};
        vecs[5] = '{0, 2, 0, 1'b0};
        vecs[6] = '{0, NUM_CH - 1, 0, 1'b0};

        rst = 1'b1;
        cfg_we = 1'b0; cfg_ch = '0; cfg_mul = '0; cfg_bias = '0; cfg_shift = '0;
        start = 1'b0; num_ch = '0; num_pix = '0; relu6_max_in = '0; relu6_en_in = 1'b0;
        in_valid = 1'b0; in_acc = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_o("reset_out", dut_out(), '0);
        chk_b("reset_busy", busy, 1'b0);
        chk_b("reset_done", done, 1'b0);
        chk_b("reset_err", err, 1'b0);
        chk_b("reset_out_valid", out_valid, 1'b0);
        chk_b("reset_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int c = 0; c < NUM_CH; c++) cfg_write(c);

        run_layer(3, 2, 0, 0, 10, 1'b0, 1'b0);
        run_layer(3, 2, 1, 0, 10, 1'b0, 1'b0);
        run_layer(3, 2, 0, 0, 10, 1'b1, 1'b0);

        d0 = done_cnt;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            if (vecs[i].op == 1) begin
                start = 1'b1;
                num_ch = (CH_W+1)'(vecs[i].a);
                num_pix = PIX_W'(vecs[i].b);
            end else begin
                cfg_we = 1'b1;
                cfg_ch = CH_W'(vecs[i].a);
                cfg_mul = MUL_W'($urandom);
                cfg_bias = $urandom;
                cfg_shift = SHIFT_W'($urandom);
                if (!vecs[i].exp_err) begin
                    m_mul[vecs[i].a] = cfg_mul;
                    m_bias[vecs[i].a] = cfg_bias;
                    m_shift[vecs[i].a] = cfg_shift;
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
            cfg_we = 1'b0;
            @(negedge clk);
            chk_b($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            chk_b($sformatf("vec%0d_busy", i), busy, 1'b0);
            @(negedge clk);
            chk_b($sformatf("vec%0d_err_pulse", i), err, 1'b0);
        end
        chk_i("vec_no_done", done_cnt - d0, 0);

        run_layer(NUM_CH, 1, 0, 0, 100, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++)
            run_layer($urandom_range(1, NUM_CH), $urandom_range(1, 4), 2, 1, -1, 1'b0, (r % 2) == 1);

        // Reset while the fourth element of a 3x4 layer is being offered.
        @(posedge clk); #1;
        start_layer(3, 4);
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 3; c++)
                exp_q.push_back(model_elem(c, ACC_W'(200 + p*3 + c), (p == 3) && (c == 2)));
        @(posedge clk); #1;
        start = 1'b0;
        d0 = done_cnt;
        k = 0;
        lc = 0;
        while (k < 3 && lc < 100) begin
            in_valid = 1'b1;
            in_acc = ACC_W'(200 + k);
            out_ready = 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
            lc++;
        end
        chk_i("pre_rst_accepted", k, 3);
        rst = 1'b1;
        in_valid = 1'b1;
        in_acc = ACC_W'(203);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk_b("rst_out_valid", out_valid, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_done", done, 1'b0);
        chk_o("rst_out_regs", dut_out(), '0);
        exp_q.delete();
        @(negedge clk);
        chk_b("rst_done_late", done, 1'b0);
        chk_i("rst_no_done", done_cnt - d0, 0);

        // Single-element layer after reset reuses the retained table[0].
        @(posedge clk); #1;
        start_layer(1, 1);
        exp_q.push_back(model_elem(0, ACC_W'(32'h8000_0123), 1'b1));
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        in_acc = ACC_W'(32'h8000_0123);
        out_ready = 1'b1;
        @(negedge clk);
        chk_b("single_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk_b("single_latency", out_valid, 1'b1);
        chk_b("single_last", out_last, 1'b1);
        chk_b("single_drain_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk_b("single_done", done, 1'b1);
        chk_b("single_out_valid_clr", out_valid, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk_b("single_done_pulse", done, 1'b0);
        chk_i("single_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
